// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - FX2 shift/rotate opcodes, widths and core result type
package fx2_pkg;

  localparam int DATA_W = 128;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 7;
  localparam int HW_W   = 16;
  localparam int WD_W   = 32;
  localparam int N_HW   = DATA_W / HW_W;
  localparam int N_WD   = DATA_W / WD_W;

  localparam logic [OP_W-1:0] OP_ROTHI = 4'h0;
  localparam logic [OP_W-1:0] OP_ROTI  = 4'h1;
  localparam logic [OP_W-1:0] OP_SHLHI = 4'h2;
  localparam logic [OP_W-1:0] OP_SHLI  = 4'h3;

  typedef struct packed {
    logic              illegal;
    logic [DATA_W-1:0] data;
  } core_res_t;

endpackage

// File: rtl/fx2_shift_core.sv
// rtl/fx2_shift_core.sv - combinational FX2 rotate/shift datapath
// Operands arrive big-endian ([0:N]); they are copied to descending vectors so slices read naturally.
module fx2_shift_core
  import fx2_pkg::*;
(
  input  logic [OP_W-1:0]    i_op,
  input  logic [0:DATA_W-1]  i_ra,
  input  logic [0:IMM_W-1]   i_imm7,
  output core_res_t          o_res
);

  logic [DATA_W-1:0] w_ra;
  logic [IMM_W-1:0]  w_imm;
  logic              w_unused_imm_msb;
  logic [2*HW_W-1:0] w_hw2;
  logic [2*WD_W-1:0] w_wd2;

  assign w_ra  = i_ra;
  assign w_imm = i_imm7;
  // No op reads the top immediate bit (big-endian bit 0).
  assign w_unused_imm_msb = w_imm[IMM_W-1];

  always_comb begin
    o_res = '0;
    w_hw2 = '0;
    w_wd2 = '0;
    case (i_op)
      OP_ROTHI: begin
        for (int h = 0; h < N_HW; h++) begin
          w_hw2 = {w_ra[h*HW_W +: HW_W], w_ra[h*HW_W +: HW_W]} << w_imm[3:0];
          o_res.data[h*HW_W +: HW_W] = w_hw2[2*HW_W-1 -: HW_W];
        end
      end
      OP_ROTI: begin
        for (int w = 0; w < N_WD; w++) begin
          w_wd2 = {w_ra[w*WD_W +: WD_W], w_ra[w*WD_W +: WD_W]} << w_imm[4:0];
          o_res.data[w*WD_W +: WD_W] = w_wd2[2*WD_W-1 -: WD_W];
        end
      end
      OP_SHLHI: begin
        // Shift counts 16..31 push every bit out of the halfword.
        for (int h = 0; h < N_HW; h++) begin
          o_res.data[h*HW_W +: HW_W] = w_imm[4] ? '0 : (w_ra[h*HW_W +: HW_W] << w_imm[3:0]);
        end
      end
      OP_SHLI: begin
        for (int w = 0; w < N_WD; w++) begin
          o_res.data[w*WD_W +: WD_W] = w_imm[5] ? '0 : (w_ra[w*WD_W +: WD_W] << w_imm[4:0]);
        end
      end
      default: o_res.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fx2_rot_pipe_ctrl.sv
// rtl/fx2_rot_pipe_ctrl.sv - FX2 even-pipe shift/rotate issue and writeback sequencer
// Stage 1 is the issue cycle (result computed combinationally); registers hold stages 2..DEPTH.
module fx2_rot_pipe_ctrl
  import fx2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [0:DATA_W-1] issue_ra,
  input  logic [0:IMM_W-1]  issue_imm7,
  input  logic [RT_W-1:0]   issue_rt,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RT_W-1:0]   wb_rt,
  output logic [0:DATA_W-1] wb_data,
  output logic              wb_illegal,
  input  logic [RT_W-1:0]   chk_rt,
  output logic              chk_hit
);

  localparam int NREG = DEPTH - 1;
  localparam int LAST = NREG - 1;

  logic [NREG-1:0]   r_vld;
  logic [NREG-1:0]   r_ill;
  logic [RT_W-1:0]   r_rt   [NREG];
  logic [DATA_W-1:0] r_data [NREG];

  core_res_t w_core;
  logic      w_stall;

  fx2_shift_core u_core (
    .i_op   (issue_op),
    .i_ra   (issue_ra),
    .i_imm7 (issue_imm7),
    .o_res  (w_core)
  );

  assign w_stall     = r_vld[LAST] & ~wb_ready;
  assign issue_ready = ~w_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_ill <= '0;
      for (int k = 0; k < NREG; k++) begin
        r_rt[k]   <= '0;
        r_data[k] <= '0;
      end
    end else if (w_stall) begin
      // The last stage is committed; flush only kills the younger stages behind it.
      for (int k = 0; k < LAST; k++) begin
        if (flush) r_vld[k] <= 1'b0;
      end
    end else begin
      r_vld[0]  <= issue_valid & ~flush;
      r_ill[0]  <= w_core.illegal;
      r_rt[0]   <= issue_rt;
      r_data[0] <= w_core.data;
      for (int k = 1; k < NREG; k++) begin
        r_vld[k]  <= r_vld[k-1] & ~flush;
        r_ill[k]  <= r_ill[k-1];
        r_rt[k]   <= r_rt[k-1];
        r_data[k] <= r_data[k-1];
      end
    end
  end

  assign wb_valid   = r_vld[LAST];
  assign wb_illegal = r_ill[LAST];
  assign wb_rt      = r_rt[LAST];
  assign wb_data    = r_data[LAST];

  always_comb begin
    chk_hit = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (r_vld[k] && (r_rt[k] == chk_rt)) chk_hit = 1'b1;
    end
  end

endmodule
